// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// LSB first, through a ripple slice with a registered inter-digit carry.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_sub: DIGIT must be >=1 and divide WIDTH exactly");
        end
    endgenerate

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             carry_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    // Ripple slice: c[DIGIT-1] is the carry into the digit's top bit, which on the
    // last digit is the carry into the operand MSB used for signed overflow.
    assign c[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
            assign dsum[gi]  = a_sh_reg[gi] ^ b_sh_reg[gi] ^ c[gi];
            assign c[gi + 1] = (a_sh_reg[gi] & b_sh_reg[gi])
                             | (a_sh_reg[gi] & c[gi])
                             | (b_sh_reg[gi] & c[gi]);
        end
    endgenerate

    // Earlier digits accumulate at the top of res_reg and slide down as new ones arrive.
    generate
        if (N > 1) begin : g_multi
            logic [WIDTH-DIGIT-1:0] res_reg;

            assign res_next = {dsum, res_reg};
            assign a_shift  = {{DIGIT{1'b0}}, a_sh_reg[WIDTH-1:DIGIT]};
            assign b_shift  = {{DIGIT{1'b0}}, b_sh_reg[WIDTH-1:DIGIT]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_reg <= '0;
                end else if (state_reg == RUN) begin
                    res_reg <= res_next[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_single
            assign res_next = dsum;
            assign a_shift  = '0;
            assign b_shift  = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            carry_reg     <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        // Subtraction runs as A + ~B + !Cin
                        a_sh_reg     <= A;
                        b_sh_reg     <= B ^ {WIDTH{sub}};
                        carry_reg    <= Cin ^ sub;
                        count_reg    <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_shift;
                    b_sh_reg  <= b_shift;
                    carry_reg <= c[DIGIT];
                    count_reg <= count_reg + CNT_W'(1);
                    if (count_reg == LAST) begin
                        sum_reg       <= res_next;
                        cout_reg      <= c[DIGIT];
                        ovf_reg       <= c[DIGIT-1] ^ c[DIGIT];
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign Sum       = sum_reg;
    assign Cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three configurations (8x1, 8x4, 1x1) checked against an
// integer-arithmetic reference model with randomized gaps and backpressure.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid_t [3];
    logic       in_ready_t [3];
    logic [7:0] a_t        [3];
    logic [7:0] b_t        [3];
    logic       cin_t      [3];
    logic       sub_t      [3];
    logic       out_valid_t[3];
    logic       out_ready_t[3];
    logic [7:0] sum_t      [3];
    logic       cout_t     [3];
    logic       ovf_t      [3];
    logic [0:0] sum1;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_t[0]), .in_ready(in_ready_t[0]),
        .A(a_t[0]), .B(b_t[0]), .Cin(cin_t[0]), .sub(sub_t[0]),
        .out_valid(out_valid_t[0]), .out_ready(out_ready_t[0]),
        .Sum(sum_t[0]), .Cout(cout_t[0]), .ovf(ovf_t[0])
    );

    serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_t[1]), .in_ready(in_ready_t[1]),
        .A(a_t[1]), .B(b_t[1]), .Cin(cin_t[1]), .sub(sub_t[1]),
        .out_valid(out_valid_t[1]), .out_ready(out_ready_t[1]),
        .Sum(sum_t[1]), .Cout(cout_t[1]), .ovf(ovf_t[1])
    );

    serial_add_sub #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_t[2]), .in_ready(in_ready_t[2]),
        .A(a_t[2][0:0]), .B(b_t[2][0:0]), .Cin(cin_t[2]), .sub(sub_t[2]),
        .out_valid(out_valid_t[2]), .out_ready(out_ready_t[2]),
        .Sum(sum1), .Cout(cout_t[2]), .ovf(ovf_t[2])
    );
    assign sum_t[2] = {7'b0, sum1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_w(input int d);
        return (d == 2) ? 1 : 8;
    endfunction

    function automatic int cfg_n(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 2 : 1);
    endfunction

    // Reference: plain integer arithmetic on the signed/unsigned interpretations
    function automatic void model(input int w, input int a, input int b, input int cin,
                                  input int s, output int sum, output int cout, output int ov);
        int mask, sa, sb, r, sr, hi, lo;
        mask = (1 << w) - 1;
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        if (s == 0) begin
            r    = a + b + cin;
            cout = (r >> w) & 1;
            sr   = sa + sb + cin;
        end else begin
            r    = a - b - cin;
            cout = (r >= 0) ? 1 : 0;
            sr   = sa - sb - cin;
        end
        hi   = (1 << (w - 1)) - 1;
        lo   = -(1 << (w - 1));
        sum  = r & mask;
        ov   = (sr > hi || sr < lo) ? 1 : 0;
    endfunction

    task automatic do_op(input int d, input int a, input int b, input int cin, input int s,
                         input int hold, input bit toggle);
        int es, ec, eo, lat, k;
        bit got;
        model(cfg_w(d), a, b, cin, s, es, ec, eo);
        k = 0;
        while (!in_ready_t[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", 32'(in_ready_t[d]), 1);
        a_t[d]        = 8'(a);
        b_t[d]        = 8'(b);
        cin_t[d]      = cin[0];
        sub_t[d]      = s[0];
        in_valid_t[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_t[d] = 1'b0;
        a_t[d]        = 8'($urandom);
        b_t[d]        = 8'($urandom);
        cin_t[d]      = 1'($urandom);
        sub_t[d]      = 1'($urandom);
        chk("in_ready_drop", 32'(in_ready_t[d]), 0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = out_valid_t[d];
        end
        chk("latency", lat, cfg_n(d));
        chk("sum", 32'(sum_t[d]), es);
        chk("cout", 32'(cout_t[d]), ec);
        chk("ovf", 32'(ovf_t[d]), eo);
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin
                in_valid_t[d] = ~in_valid_t[d];
                a_t[d]        = 8'($urandom);
                b_t[d]        = 8'($urandom);
            end
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid_t[d]), 1);
            chk("bp_in_ready", 32'(in_ready_t[d]), 0);
            chk("bp_sum", 32'(sum_t[d]), es);
            chk("bp_cout", 32'(cout_t[d]), ec);
            chk("bp_ovf", 32'(ovf_t[d]), eo);
        end
        in_valid_t[d]  = 1'b0;
        out_ready_t[d] = 1'b1;
        @(negedge clk);
        out_ready_t[d] = 1'b0;
        chk("hs_out_valid", 32'(out_valid_t[d]), 0);
        chk("hs_in_ready", 32'(in_ready_t[d]), 1);
        chk("hold_sum", 32'(sum_t[d]), es);
        $display("op cfg=%0d a=%0h b=%0h cin=%0d sub=%0d -> sum=%0h cout=%0d ovf=%0d lat=%0d",
                 d, a, b, cin, s, sum_t[d], cout_t[d], ovf_t[d], lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c, s, seen;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid_t[d]  = 1'b0;
            out_ready_t[d] = 1'b0;
            a_t[d]         = '0;
            b_t[d]         = '0;
            cin_t[d]       = 1'b0;
            sub_t[d]       = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", 32'(in_ready_t[d]), 0);
            chk("rst_out_valid", 32'(out_valid_t[d]), 0);
            chk("rst_sum", 32'(sum_t[d]), 0);
            chk("rst_cout", 32'(cout_t[d]), 0);
            chk("rst_ovf", 32'(ovf_t[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", 32'(in_ready_t[0]), 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_post", 32'(in_ready_t[0]), 1);
        @(negedge clk);

        // Full-adder truth table
        for (int i = 0; i < 8; i++)
            do_op(2, (i >> 2) & 1, (i >> 1) & 1, i & 1, 0, 0, 1'b0);

        for (int d = 0; d < 2; d++) begin
            do_op(d, 'h5A, 'h33, 0, 0, 0, 1'b0);
            do_op(d, 'h10, 'h20, 0, 1, 0, 1'b0);
            do_op(d, 'h80, 'h01, 0, 1, 0, 1'b0);
            do_op(d, 'hFF, 'h01, 1, 0, 0, 1'b0);
        end

        // Backpressure with in_valid toggling on the stalled unit
        do_op(0, 'h5A, 'h33, 0, 0, 5, 1'b1);

        // Asynchronous reset during RUN
        a_t[0] = 8'h12; b_t[0] = 8'h34; cin_t[0] = 1'b0; sub_t[0] = 1'b0;
        in_valid_t[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_t[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid_t[0]), 0);
        chk("mid_rst_sum", 32'(sum_t[0]), 0);
        chk("mid_rst_cout", 32'(cout_t[0]), 0);
        chk("mid_rst_ovf", 32'(ovf_t[0]), 0);
        chk("mid_rst_in_ready", 32'(in_ready_t[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready_pre", 32'(in_ready_t[0]), 0);
        @(posedge clk);
        #1;
        chk("mid_rel_in_ready_post", 32'(in_ready_t[0]), 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid_t[0]) seen++;
        end
        chk("no_stale_out_valid", seen, 0);
        do_op(0, 'hC3, 'h7E, 1, 1, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            c = int'($urandom_range(0, 1));
            s = int'($urandom_range(0, 1));
            do_op(1, a, b, c, s, int'($urandom_range(0, 3)), 1'($urandom));
        end
        for (int i = 0; i < 100; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            c = int'($urandom_range(0, 1));
            s = int'($urandom_range(0, 1));
            do_op(0, a, b, c, s, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
